// File: rtl/ysyx_25030093_imem_resp.sv
// Fetch-side instruction memory responder: accepts a PC, waits LATENCY cycles and
// returns the addressed word (or an error for misaligned/out-of-window PCs).
module ysyx_25030093_imem_resp #(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 1,
   localparam int         AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_inst,
   output logic          rsp_err,
   input  logic          flush,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data
);

   // state  | meaning
   // IDLE   | no request in flight, ready to accept
   // WAIT   | request accepted, latency counter running
   // RESP   | response held on rsp_* until handshake
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          err_q, err_d;
   logic [31:0]   inst_q, inst_d;
   logic          rerr_q, rerr_d;

   logic [31:0]   mem [DEPTH];

   logic [29:0]   off_w;
   logic [AW-1:0] req_idx;
   logic          req_err;
   logic          accept;

   // BASE is word aligned, so the word offset can be formed from the upper PC bits alone
   assign off_w   = req_addr[31:2] - BASE[31:2];
   assign req_idx = off_w[AW-1:0];
   assign req_err = (req_addr[1:0] != 2'b00) || (off_w[29:AW] != '0);

   assign rsp_valid = (state_q == S_RESP);
   assign req_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
   assign accept    = req_valid && req_ready;
   assign rsp_inst  = inst_q;
   assign rsp_err   = rerr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      inst_d  = inst_q;
      rerr_d  = rerr_q;
      if (accept) begin
         idx_d = req_idx;
         err_d = req_err;
         if (LATENCY == 1) begin
            state_d = S_RESP;
            cnt_d   = '0;
            inst_d  = req_err ? '0 : mem[req_idx];
            rerr_d  = req_err;
         end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
         end
      end else if ((state_q == S_RESP) && rsp_ready) begin
         state_d = S_IDLE;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            inst_d  = err_q ? '0 : mem[idx_q];
            rerr_d  = err_q;
         end
      end
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         inst_d  = inst_q;
         rerr_d  = rerr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         inst_q  <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         inst_q  <= inst_d;
         rerr_q  <= rerr_d;
      end
   end

   // Store is not reset; a same-edge write lands after the sample, so the response sees the old word
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_imem_resp.sv
// Bench: three responders (LATENCY 1, 3, 4) share stimulus and are checked every cycle
// against a timestamp-based transaction model plus directed literal checks.
module tb_ysyx_25030093_imem_resp;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 4096;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        rsp_ready;
   logic        flush;
   logic        load_en;
   logic [11:0] load_addr;
   logic [31:0] load_data;

   logic        rdy_o  [3];
   logic        vld_o  [3];
   logic        err_o  [3];
   logic [31:0] inst_o [3];

   int          n_chk = 0;
   int          n_bad = 0;

   // reference model state
   int          lat [3] = '{1, 3, 4};
   bit          m_pend [3];
   bit          m_have [3];
   bit          m_err  [3];
   logic [31:0] m_addr [3];
   logic [31:0] m_inst [3];
   int          m_samp [3];
   int          edge_n;
   logic [31:0] mm [DEPTH];

   ysyx_25030093_imem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_o[0]), .req_addr(req_addr),
      .rsp_valid(vld_o[0]), .rsp_ready(rsp_ready), .rsp_inst(inst_o[0]), .rsp_err(err_o[0]),
      .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   ysyx_25030093_imem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_o[1]), .req_addr(req_addr),
      .rsp_valid(vld_o[1]), .rsp_ready(rsp_ready), .rsp_inst(inst_o[1]), .rsp_err(err_o[1]),
      .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   ysyx_25030093_imem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_o[2]), .req_addr(req_addr),
      .rsp_valid(vld_o[2]), .rsp_ready(rsp_ready), .rsp_inst(inst_o[2]), .rsp_err(err_o[2]),
      .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void lookup(input logic [31:0] a, output bit e, output logic [31:0] w);
      logic [31:0] off;
      off = a - BASE;
      e   = (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
      w   = e ? 32'h0 : mm[off >> 2];
   endfunction

   function automatic bit exp_rdy(input int k);
      return !flush && ((!m_pend[k] && !m_have[k]) || (m_have[k] && rsp_ready));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_pend[k] = 1'b0;
         m_have[k] = 1'b0;
      end
   endtask

   // Applies the effect of one rising edge using the inputs present before it.
   task automatic model_edge();
      bit r [3];
      for (int k = 0; k < 3; k++) r[k] = exp_rdy(k);
      edge_n++;
      for (int k = 0; k < 3; k++) begin
         if (flush) begin
            m_pend[k] = 1'b0;
            m_have[k] = 1'b0;
         end else begin
            if (m_have[k] && rsp_ready) m_have[k] = 1'b0;
            if (req_valid && r[k]) begin
               m_pend[k] = 1'b1;
               m_addr[k] = req_addr;
               m_samp[k] = edge_n + lat[k] - 1;
            end
            if (m_pend[k] && m_samp[k] == edge_n) begin
               lookup(m_addr[k], m_err[k], m_inst[k]);
               m_have[k] = 1'b1;
               m_pend[k] = 1'b0;
            end
         end
      end
      if (load_en) mm[load_addr] = load_data;
   endtask

   task automatic tick();
      #2;
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("rdy%0d", k), 32'(rdy_o[k]), 32'(exp_rdy(k)));
         check_val($sformatf("vld%0d", k), 32'(vld_o[k]), 32'(m_have[k]));
         if (m_have[k]) begin
            check_val($sformatf("inst%0d", k), inst_o[k], m_inst[k]);
            check_val($sformatf("err%0d", k), 32'(err_o[k]), 32'(m_err[k]));
         end
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      flush     = 1'b0;
      load_en   = 1'b0;
      repeat (6) tick();
   endtask

   task automatic load_word(input int idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = 12'(idx);
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   logic [31:0] err_addrs [3] = '{32'h8000_0002, 32'h8000_4000, 32'h7FFF_FFFC};
   bit          seen;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0; edge_n = 0;
      model_reset();
      #3;
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("rst_vld%0d", k), 32'(vld_o[k]), 32'h0);
         check_val($sformatf("rst_inst%0d", k), inst_o[k], 32'h0);
         check_val($sformatf("rst_err%0d", k), 32'(err_o[k]), 32'h0);
         check_val($sformatf("rst_rdy%0d", k), 32'(rdy_o[k]), 32'h1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 64; i++) load_word(i, $urandom);
      load_word(0, 32'h0000_0413);
      load_word(1, 32'h0010_0093);
      load_word(2, 32'h1234_5678);
      load_word(5, 32'h5555_AAAA);
      drain();

      // back-to-back fetches on the single-cycle responder
      req_valid = 1'b1; req_addr = 32'h8000_0000; rsp_ready = 1'b1;
      tick();
      check_val("t1_vld", 32'(vld_o[0]), 32'h1);
      check_val("t1_inst0", inst_o[0], 32'h0000_0413);
      check_val("t1_err0", 32'(err_o[0]), 32'h0);
      req_addr = 32'h8000_0004;
      #1 check_val("t1_b2b_rdy", 32'(rdy_o[0]), 32'h1);
      tick();
      check_val("t1_inst1", inst_o[0], 32'h0010_0093);
      drain();

      // latency 3 with a stalled initiator
      req_valid = 1'b1; req_addr = 32'h8000_0008; rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      check_val("t2_early_vld", 32'(vld_o[1]), 32'h0);
      tick();
      check_val("t2_vld", 32'(vld_o[1]), 32'h1);
      check_val("t2_inst", inst_o[1], 32'h1234_5678);
      repeat (3) begin
         tick();
         check_val("t2_hold_vld", 32'(vld_o[1]), 32'h1);
         check_val("t2_hold_inst", inst_o[1], 32'h1234_5678);
         check_val("t2_hold_rdy", 32'(rdy_o[1]), 32'h0);
      end
      rsp_ready = 1'b1;
      #1 check_val("t2_hs_rdy", 32'(rdy_o[1]), 32'h1);
      drain();

      // error responses
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = err_addrs[i]; rsp_ready = 1'b1;
         tick();
         check_val($sformatf("t3_err%0d", i), 32'(err_o[0]), 32'h1);
         check_val($sformatf("t3_inst%0d", i), inst_o[0], 32'h0);
      end
      drain();

      // flush during WAIT on the latency-4 responder
      req_valid = 1'b1; req_addr = 32'h8000_0008;
      tick();
      req_valid = 1'b0;
      tick();
      flush = 1'b1;
      #1 check_val("t4_flush_rdy", 32'(rdy_o[2]), 32'h0);
      tick();
      flush = 1'b0;
      #1;
      check_val("t4_post_rdy", 32'(rdy_o[2]), 32'h1);
      check_val("t4_post_vld", 32'(vld_o[2]), 32'h0);
      req_valid = 1'b1; req_addr = 32'h8000_0004;
      tick();
      req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (vld_o[2]) seen = 1'b1;
      end
      check_val("t4_rsp_seen", 32'(seen), 32'h1);
      check_val("t4_inst", inst_o[2], 32'h0010_0093);
      drain();

      // preload write colliding with the sample edge
      req_valid = 1'b1; req_addr = 32'h8000_0014;
      load_en = 1'b1; load_addr = 12'd5; load_data = 32'hDEAD_BEEF;
      tick();
      load_en = 1'b0;
      check_val("t5_old", inst_o[0], 32'h5555_AAAA);
      tick();
      check_val("t5_new", inst_o[0], 32'hDEAD_BEEF);
      drain();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         req_valid = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 9);
         if (sel < 8)       req_addr = BASE + 32'(4 * $urandom_range(0, 63));
         else if (sel == 8) req_addr = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
         else               req_addr = ($urandom_range(0, 1) != 0) ? BASE + 32'h4000 + 32'(4 * $urandom_range(0, 255))
                                                                  : BASE - 32'(4 * $urandom_range(1, 256));
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         load_en   = ($urandom_range(0, 9) == 0);
         load_addr = 12'($urandom_range(0, 63));
         load_data = $urandom;
         tick();
      end
      drain();

      // asynchronous reset while holding a response
      req_valid = 1'b1; req_addr = 32'h8000_0004; rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      check_val("t6_pre_vld", 32'(vld_o[0]), 32'h1);
      #2 rst = 1'b1;
      #1;
      check_val("t6_vld", 32'(vld_o[0]), 32'h0);
      check_val("t6_inst", inst_o[0], 32'h0);
      check_val("t6_rdy", 32'(rdy_o[0]), 32'h1);
      model_reset();
      #1 rst = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
